// File: rtl/alu_sequencer.sv
// Sequencer on the initiator side of a combinational ALU: accepts one instruction
// at a time, reads operands from a small register file, drives the ALU and writes back.
module alu_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int OP_SIZE    = 2,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  instr_load,
    input  logic [OP_SIZE-1:0]    instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs1,
    input  logic [REG_ADDR_W-1:0] instr_rs2,
    input  logic [DATA_WIDTH-1:0] instr_imm,
    output logic [OP_SIZE-1:0]    ALU_ctrl,
    output logic [DATA_WIDTH-1:0] alu_data_1,
    output logic [DATA_WIDTH-1:0] alu_data_2,
    input  logic [DATA_WIDTH-1:0] ALU_result,
    input  logic                  zero,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero_flag,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int NREGS = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        LOAD,
        DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_regs [NREGS];
    logic [OP_SIZE-1:0]    r_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [DATA_WIDTH-1:0] r_imm;

    assign instr_ready = (r_state == IDLE);
    assign dbg_data    = r_regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            ALU_ctrl   <= '0;
            alu_data_1 <= '0;
            alu_data_2 <= '0;
            result     <= '0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_op    <= instr_op;
                        r_rd    <= instr_rd;
                        r_rs1   <= instr_rs1;
                        r_rs2   <= instr_rs2;
                        r_imm   <= instr_imm;
                        r_state <= instr_load ? LOAD : READ;
                    end
                end
                // Operands are captured here, before the EXEC write, so rd may alias rs1/rs2.
                READ: begin
                    alu_data_1 <= r_regs[r_rs1];
                    alu_data_2 <= r_regs[r_rs2];
                    ALU_ctrl   <= r_op;
                    r_state    <= EXEC;
                end
                EXEC: begin
                    r_regs[r_rd] <= ALU_result;
                    result       <= ALU_result;
                    zero_flag    <= zero;
                    done         <= 1'b1;
                    r_state      <= DONE;
                end
                LOAD: begin
                    r_regs[r_rd] <= r_imm;
                    result       <= r_imm;
                    done         <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: table of load/ALU instructions with a done-driven
// scoreboard, plus hand sequences for back-to-back issue and reset corners.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic       instr_load;
    logic [1:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic [3:0] instr_imm;
    logic [1:0] ALU_ctrl;
    logic [3:0] alu_data_1;
    logic [3:0] alu_data_2;
    logic [3:0] ALU_result;
    logic       zero;
    logic       done;
    logic [3:0] result;
    logic       zero_flag;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_WIDTH(4), .OP_SIZE(2), .REG_ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_load(instr_load), .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .ALU_ctrl(ALU_ctrl), .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
        .ALU_result(ALU_result), .zero(zero),
        .done(done), .result(result), .zero_flag(zero_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Combinational ALU that the sequencer drives.
    always_comb begin
        case (ALU_ctrl)
            2'd0:    ALU_result = alu_data_1 + alu_data_2;
            2'd1:    ALU_result = alu_data_1 - alu_data_2;
            2'd2:    ALU_result = alu_data_1 & alu_data_2;
            default: ALU_result = alu_data_1 | alu_data_2;
        endcase
    end
    assign zero = (ALU_result == 4'h0);

    typedef struct {
        logic       ld;
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
        logic [3:0] exp_res;
        logic       exp_z;
    } vec_t;

    typedef struct {
        logic [1:0] rd;
        logic [3:0] res;
        logic       z;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mregs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse retires the oldest outstanding instruction.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 expected=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                dbg_addr = e.rd;
                #1;
                chk("sb_result", result, e.res);
                chk("sb_zero_flag", zero_flag, e.z);
                chk("sb_dbg_rd", dbg_data, e.res);
            end
        end
    end

    task automatic drive(input vec_t v);
        instr_valid = 1'b1;
        instr_load  = v.ld;
        instr_op    = v.op;
        instr_rd    = v.rd;
        instr_rs1   = v.rs1;
        instr_rs2   = v.rs2;
        instr_imm   = v.imm;
    endtask

    task automatic issue(input vec_t v);
        int lat;
        exp_t e;
        logic [3:0] op1, op2;
        @(negedge clk);
        chk("ready_before_issue", instr_ready, 1'b1);
        op1 = mregs[v.rs1];
        op2 = mregs[v.rs2];
        drive(v);
        e.rd = v.rd; e.res = v.exp_res; e.z = v.exp_z;
        sb.push_back(e);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("ready_busy", instr_ready, 1'b0);
            if (c == 2 && !v.ld) begin
                chk("exec_ctrl", ALU_ctrl, v.op);
                chk("exec_d1", alu_data_1, op1);
                chk("exec_d2", alu_data_2, op2);
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, v.ld ? 2 : 3);
        mregs[v.rd] = v.exp_res;
    endtask

    vec_t vecs[15];

    initial begin
        vec_t a, b;
        logic [6:0] done_bits, ready_bits;

        //            ld    op    rd    rs1   rs2   imm    res    z
        vecs[0]  = '{1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 4'h5, 4'h5, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 4'h3, 4'h3, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 4'h0, 4'h8, 1'b0};
        vecs[3]  = '{1'b0, 2'd1, 2'd0, 2'd1, 2'd1, 4'h0, 4'h0, 1'b1};
        vecs[4]  = '{1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1};
        vecs[5]  = '{1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 4'hF, 4'hF, 1'b1};
        vecs[6]  = '{1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 4'h1, 4'h1, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 2'd0, 2'd1, 2'd2, 4'h0, 4'h0, 1'b1};
        vecs[8]  = '{1'b0, 2'd1, 2'd3, 2'd2, 2'd1, 4'h0, 4'h2, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 4'hC, 4'hC, 1'b0};
        vecs[10] = '{1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 2'd3, 2'd1, 2'd2, 4'h0, 4'h8, 1'b0};
        vecs[12] = '{1'b0, 2'd3, 2'd0, 2'd1, 2'd2, 4'h0, 4'hE, 1'b0};
        vecs[13] = '{1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 4'h6, 4'h6, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 2'd1, 2'd1, 2'd1, 4'h0, 4'hC, 1'b0};

        for (int i = 0; i < 4; i++) mregs[i] = 4'h0;
        reset = 1'b1; instr_valid = 1'b0; instr_load = 1'b0; instr_op = 2'd0;
        instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 4'h0; dbg_addr = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 4'h0);
        chk("rst_zero_flag", zero_flag, 1'b0);
        chk("rst_alu_ctrl", ALU_ctrl, 2'd0);
        chk("rst_d1", alu_data_1, 4'h0);
        chk("rst_d2", alu_data_2, 4'h0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = r[1:0];
            #1 chk("rst_reg", dbg_data, 4'h0);
        end

        for (int i = 0; i < 15; i++) issue(vecs[i]);

        // Back-to-back: valid stays high; second instruction waits for IDLE.
        a = '{1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 4'h9, 4'h9, 1'b0};
        b = '{1'b0, 2'd0, 2'd3, 2'd0, 2'd1, 4'h0, 4'h5, 1'b0};
        @(negedge clk);
        drive(a);
        sb.push_back('{a.rd, a.exp_res, a.exp_z});
        @(posedge clk);
        #1 drive(b);
        sb.push_back('{b.rd, b.exp_res, b.exp_z});
        done_bits = '0; ready_bits = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            done_bits[c-1]  = done;
            ready_bits[c-1] = instr_ready;
            if (c == 3) begin
                @(posedge clk);
                #1 instr_valid = 1'b0;
            end
        end
        chk("b2b_done_pattern", done_bits, 7'b0100010);
        chk("b2b_ready_pattern", ready_bits, 7'b1000100);

        // Reset during EXEC aborts the write and the done pulse.
        issue('{1'b1, 2'd0, 2'd3, 2'd0, 2'd0, 4'h7, 4'h7, 1'b0});
        @(negedge clk);
        drive('{1'b0, 2'd0, 2'd3, 2'd1, 2'd2, 4'h0, 4'h0, 1'b0});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_exec", ALU_ctrl == 2'd0 && instr_ready == 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dbg_addr = 2'd3;
        #1 chk("abort_r3_cleared", dbg_data, 4'h0);
        chk("abort_no_done", done, 1'b0);
        chk("abort_result", result, 4'h0);
        @(negedge clk);
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_no_done2", done, 1'b0);

        // Valid in the reset cycle is dropped.
        @(negedge clk);
        reset = 1'b1;
        drive('{1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 4'hF, 4'hF, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b0;
        chk("rstv_ready", instr_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("rstv_no_done", done, 1'b0);
        end
        dbg_addr = 2'd2;
        #1 chk("rstv_r2", dbg_data, 4'h0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the datapath ALU interface.
- Accepts one register-to-register instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Drives the op-select and operand inputs of the combinational ALU, then captures its result and zero flag and writes the result back.
- Sits between the instruction source and the ALU. The ALU remains a separate, purely combinational instance.

Parameters:
- DATA_WIDTH, 4, bits per register and ALU operand.
- OP_SIZE, 2, width of the ALU op-select.
- REG_ADDR_W, 2, register address width; the register file holds 2**REG_ADDR_W entries.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_load  input  1  1 = load immediate into rd; 0 = ALU operation.
- instr_op  input  OP_SIZE  ALU operation: 0 add, 1 sub, 2 and, 3 or.
- instr_rd  input  REG_ADDR_W  destination register.
- instr_rs1  input  REG_ADDR_W  source register for data_1.
- instr_rs2  input  REG_ADDR_W  source register for data_2.
- instr_imm  input  DATA_WIDTH  immediate for loads.
- ALU_ctrl  output  OP_SIZE  to ALU op-select.
- alu_data_1  output  DATA_WIDTH  to ALU data_1.
- alu_data_2  output  DATA_WIDTH  to ALU data_2.
- ALU_result  input  DATA_WIDTH  from ALU.
- zero  input  1  from ALU.
- done  output  1  one-cycle pulse: instruction retired.
- result  output  DATA_WIDTH  value written to rd by the last retired instruction.
- zero_flag  output  1  ALU zero captured by the last retired ALU instruction.
- dbg_addr  input  REG_ADDR_W  register-file debug read address.
- dbg_data  output  DATA_WIDTH  combinational read of register dbg_addr.

Behaviour:
- FSM states: IDLE, READ, EXEC, LOAD, DONE.
- instr_ready = (state == IDLE), combinational. A transfer occurs on a rising edge with instr_valid && instr_ready && !reset.
- Transfer in IDLE: latch all instr_* fields. Go to LOAD if instr_load = 1, otherwise READ.
- READ (1 cycle): latch reg[rs1] and reg[rs2] into operand registers, latch op into ALU_ctrl, go to EXEC.
- EXEC (1 cycle):
  - ALU_ctrl, alu_data_1 and alu_data_2 are registered and stable for the whole cycle.
  - On the closing edge: reg[rd] <= ALU_result, result <= ALU_result, zero_flag <= zero, then go to DONE.
- LOAD (1 cycle): reg[rd] <= imm and result <= imm. zero_flag is unchanged. Go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE.
- Latency, with transfer on edge 0:
  - ALU instruction: done is high in the third cycle after the transfer (READ, EXEC, DONE).
  - Load: done is high in the second cycle (LOAD, DONE).
- Throughput: a new instruction can be accepted in the cycle after DONE (IDLE).
- ALU_ctrl and alu_data_1/2 hold their last driven values outside EXEC. They do not change except on entry to EXEC.
- Arithmetic is DATA_WIDTH modular, as performed by the ALU. Overflow and borrow are discarded, with no flag.
- Register aliasing is allowed: rd may equal rs1 and/or rs2. Operands are read in READ, before the write in EXEC.
- instr_valid held high while busy: not accepted, no effect. Fields may change freely while instr_ready = 0.
- No register is hardwired to zero.
- Reset (synchronous, active-high):
  - state <= IDLE; all registers, operand registers, ALU_ctrl, alu_data_1/2, result and zero_flag <= 0; done <= 0.
  - Reset in any state aborts the instruction: no register-file write, no done pulse.
  - Reset has priority over any transfer in the same cycle.
- dbg_data reflects a write starting the cycle after the write edge.

Test Plan:
- Reset, then load R1=5 and R2=3, then ADD rd=R3, rs1=R1, rs2=R2 -> during EXEC ALU_ctrl=0, alu_data_1=5, alu_data_2=3; done in the third cycle after transfer; result=8, zero_flag=0, dbg R3=8.
- SUB R0=R1-R1 with R1=5 -> result=0, zero_flag=1, R0=0. Then load R2=0 -> result=0, zero_flag stays 1.
- Wrap: R1=0xF, R2=0x1, ADD -> 0x0, zero_flag=1. SUB R3=R2-R1 -> 0x2. AND 0xC&0xA -> 0x8. OR 0xC|0xA -> 0xE.
- Aliasing: ADD R1=R1+R1 with R1=6 -> R1=0xC. Back-to-back with instr_valid held high -> instr_ready low READ through DONE; second instruction accepted on the IDLE edge right after done; exactly one done pulse per instruction.
- Reset asserted during EXEC of ADD R3 (R3=7 beforehand) -> R3 reads 0 after reset (cleared by reset, not written by ADD); no done pulse; instr_ready high the cycle after reset deasserts.
- instr_valid=1 in the same cycle as reset -> instruction not accepted; no register change; done stays 0.
